led_matrix_scan_ctrl: RTL and testbench

LED_MATRIX_SCAN_CTRL -- requirements
Module: led_matrix_scan_ctrl

---
 rtl/led_matrix_pkg.sv | 21 ++
 rtl/scan_timer.sv | 31 +++
 rtl/led_matrix_scan_ctrl.sv | 141 ++++++++++++++
 tb/tb_led_matrix_scan_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_pkg.sv
// Shared defaults, scan FSM encoding and counter sizing for the LED matrix scanner.
// No ports: imported by led_matrix_scan_ctrl and scan_timer.
package led_matrix_pkg;

  localparam int ROWS_DEF  = 7;
  localparam int COLS_DEF  = 5;
  localparam int DWELL_DEF = 50000;
  localparam int BLANK_DEF = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LIT   = 2'd1,
    S_BLANK = 2'd2
  } scan_state_t;

  // Width able to hold 0..n-1, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_timer.sv
// Up-counter from 0 to a terminal value; tick is high in the terminal cycle.
// Ports: clk, rst_n (async low), clr (sync clear), run, last (terminal value), tick.
module scan_timer
  import led_matrix_pkg::*;
#(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         run,
  input  logic [W-1:0] last,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = run && (cnt == last);

  // Counter returns to 0 after its terminal cycle so it never exceeds last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// Column-scanned LED matrix driver with double-buffered frames and blanking.
// Ports: clk, rst_n, enable, frame_data/valid/ready, col_en (low), row_out, frame_sync.
module led_matrix_scan_ctrl
  import led_matrix_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int COLS  = COLS_DEF,
  parameter int DWELL = DWELL_DEF,
  parameter int BLANK = BLANK_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [ROWS*COLS-1:0] frame_data,
  input  logic                 frame_valid,
  output logic                 frame_ready,
  output logic [COLS-1:0]      col_en,
  output logic [ROWS-1:0]      row_out,
  output logic                 frame_sync
);

  localparam int N  = ROWS * COLS;
  localparam int CW = cnt_w(COLS);
  localparam int DW = cnt_w(DWELL);
  localparam int BW = cnt_w(BLANK);

  localparam logic [CW-1:0] COL_LAST   = CW'(COLS - 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL - 1);
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK - 1);

  scan_state_t state, state_n;

  logic [CW-1:0]   col, col_n;
  logic [N-1:0]    active, active_n;
  logic [N-1:0]    pending;
  logic            pending_full, pending_full_n;
  logic            accept, swap, boundary;
  logic            dwell_tick, blank_tick;
  logic [COLS-1:0] col_en_n;
  logic [ROWS-1:0] row_n;
  logic            sync_n;

  scan_timer #(.W(DW)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!enable),
    .run   (enable && (state == S_LIT)),
    .last  (DWELL_LAST),
    .tick  (dwell_tick)
  );

  scan_timer #(.W(BW)) u_blank (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!enable),
    .run   (enable && (state == S_BLANK)),
    .last  (BLANK_LAST),
    .tick  (blank_tick)
  );

  // Next state and column; timer ticks already imply enable.
  always_comb begin
    state_n  = state;
    col_n    = col;
    boundary = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (enable) begin
          state_n = S_LIT;
          col_n   = '0;
        end
      end
      S_LIT: begin
        if (dwell_tick) state_n = S_BLANK;
      end
      S_BLANK: begin
        if (blank_tick) begin
          state_n  = S_LIT;
          boundary = (col == COL_LAST);
          col_n    = boundary ? '0 : col + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
        col_n   = '0;
      end
    endcase
    if (!enable) begin
      state_n = S_IDLE;
      col_n   = '0;
    end
  end

  // Accept and swap are mutually exclusive: one needs an empty
  // pending slot, the other a full one. A frame accepted on the
  // boundary cycle therefore waits for the next boundary.
  always_comb begin
    accept         = frame_valid && !pending_full;
    swap           = pending_full && ((state == S_IDLE) || boundary);
    active_n       = swap ? pending : active;
    pending_full_n = accept || (pending_full && !swap);
  end

  // Outputs are built from next-state values so they change on
  // the same edge as the state and the freshly swapped frame.
  always_comb begin
    col_en_n = '1;
    row_n    = '0;
    sync_n   = 1'b0;
    if (state_n == S_LIT) begin
      col_en_n[col_n] = 1'b0;
      row_n  = active_n[int'(col_n) * ROWS +: ROWS];
      sync_n = (col_n == '0) && (state != S_LIT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      col          <= '0;
      active       <= '0;
      pending      <= '0;
      pending_full <= 1'b0;
      col_en       <= '1;
      row_out      <= '0;
      frame_sync   <= 1'b0;
    end else begin
      state        <= state_n;
      col          <= col_n;
      active       <= active_n;
      pending_full <= pending_full_n;
      if (accept) pending <= frame_data;
      col_en       <= col_en_n;
      row_out      <= row_n;
      frame_sync   <= sync_n;
    end
  end

  assign frame_ready = !pending_full;

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Self-checking bench for led_matrix_scan_ctrl (ROWS=7, COLS=5, DWELL=4, BLANK=2).
// Random frames/enable checked against a cycle-position reference model.
module tb_led_matrix_scan_ctrl;

  localparam int R  = 7;
  localparam int C  = 5;
  localparam int D  = 4;
  localparam int B  = 2;
  localparam int S  = D + B;
  localparam int P  = C * S;
  localparam int NW = R * C;
  localparam int OW = C + R + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          frame_valid = 1'b0;
  logic [NW-1:0] frame_data = '0;
  logic          frame_ready;
  logic          frame_sync;
  logic [C-1:0]  col_en;
  logic [R-1:0]  row_out;

  int total = 0;
  int bad = 0;

  // Reference model: scan position counted in cycles since start.
  logic [NW-1:0] m_act, m_pend;
  bit            m_pf, m_run;
  int            m_p;
  logic [OW-1:0] want;
  wire  [OW-1:0] got = {col_en, row_out, frame_sync, frame_ready};

  always #5 clk = ~clk;

  led_matrix_scan_ctrl #(
    .ROWS(R), .COLS(C), .DWELL(D), .BLANK(B)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .col_en      (col_en),
    .row_out     (row_out),
    .frame_sync  (frame_sync)
  );

  function automatic logic [OW-1:0] expect_now();
    int q, c;
    logic [C-1:0] ce;
    logic [R-1:0] rw;
    logic sy;
    ce = '1;
    rw = '0;
    sy = 1'b0;
    if (m_run) begin
      q = m_p % P;
      c = q / S;
      if ((q % S) < D) begin
        ce[c] = 1'b0;
        rw = m_act[c*R +: R];
        sy = (q == 0);
      end
    end
    return {ce, rw, sy, !m_pf};
  endfunction

  task automatic m_reset();
    m_act  = '0;
    m_pend = '0;
    m_pf   = 1'b0;
    m_run  = 1'b0;
    m_p    = 0;
    want   = expect_now();
  endtask

  // Advance one clock; the model consumes the inputs held before the edge.
  task automatic tick();
    logic en, fv, acc, bnd;
    logic [NW-1:0] fd;
    en = enable;
    fv = frame_valid;
    fd = frame_data;
    @(posedge clk);
    acc = fv && !m_pf;
    bnd = m_run && en && ((m_p % P) == P - 1);
    if (m_pf && (!m_run || bnd)) begin
      m_act = m_pend;
      m_pf  = 1'b0;
    end
    if (acc) begin
      m_pend = fd;
      m_pf   = 1'b1;
    end
    if (!en) begin
      m_run = 1'b0;
      m_p   = 0;
    end else if (!m_run) begin
      m_run = 1'b1;
      m_p   = 0;
    end else begin
      m_p++;
    end
    #1;
    want = expect_now();
  endtask

  function automatic logic [NW-1:0] rnd_frame();
    return NW'({$urandom, $urandom});
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    frame_valid = 1'b0;
    m_reset();
    #12;
    total++;
    if (got !== 14'b11111_0000000_0_1) begin
      bad++;
      $display("FAIL reset_hold got=%b want=%b", got, 14'b11111_0000000_0_1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL reset_release got=%b want=%b", got, want);
    end
  endtask

  task automatic test_idle_load();
    frame_data = '1;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    total++;
    if (frame_ready !== 1'b0 || got !== want) begin
      bad++;
      $display("FAIL idle_ready_drop got=%b want=%b", got, want);
    end
    tick();
    total++;
    if (frame_ready !== 1'b1 || col_en !== 5'b11111 || got !== want) begin
      bad++;
      $display("FAIL idle_copy got=%b want=%b", got, want);
    end
  endtask

  task automatic test_scan();
    logic [NW-1:0] fd;
    int last_sync;
    fd = rnd_frame();
    fd[2*R +: R] = 7'b1010101;
    frame_data = fd;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    tick();
    enable = 1'b1;
    last_sync = -1;
    for (int n = 0; n < 2 * P + 6; n++) begin
      tick();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL scan n=%0d got=%b want=%b", n, got, want);
      end
      if (n == 0) begin
        total++;
        if (col_en !== 5'b11110 || frame_sync !== 1'b1) begin
          bad++;
          $display("FAIL scan_first col=%b sync=%b want 11110/1", col_en, frame_sync);
        end
      end
      if (frame_sync) begin
        if (last_sync >= 0) begin
          total++;
          if (n - last_sync != P) begin
            bad++;
            $display("FAIL sync_period got=%0d want=%0d", n - last_sync, P);
          end
        end
        last_sync = n;
      end
      if (col_en == 5'b11011) begin
        total++;
        if (row_out !== 7'b1010101) begin
          bad++;
          $display("FAIL col2_rows got=%b want=1010101", row_out);
        end
      end else if (col_en == 5'b11111) begin
        total++;
        if (row_out !== 7'b0) begin
          bad++;
          $display("FAIL blank_rows got=%b want=0", row_out);
        end
      end
    end
  endtask

  task automatic test_midscan_load();
    logic [NW-1:0] nd;
    int n;
    n = 0;
    while (!(m_run && ((m_p % P) / S) == 1 && (m_p % S) == 0) && n < 2 * P) begin
      tick();
      n++;
    end
    total++;
    if (n >= 2 * P) begin
      bad++;
      $display("FAIL midload_wait timeout got=%0d want<%0d", n, 2 * P);
    end
    nd = rnd_frame();
    frame_data = nd;
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    frame_data = rnd_frame();
    n = 0;
    while (frame_sync !== 1'b1 && n < 2 * P) begin
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL midload n=%0d got=%b want=%b", n, got, want);
      end
      tick();
      n++;
    end
    total++;
    if (frame_sync !== 1'b1 || row_out !== nd[R-1:0] || got !== want) begin
      bad++;
      $display("FAIL midload_show row=%b want=%b", row_out, nd[R-1:0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [NW-1:0] nd1, nd2;
    int n;
    n = 0;
    while (!(m_run && (m_p % P) == P - 1 && !m_pf) && n < 3 * P) begin
      tick();
      n++;
    end
    total++;
    if (n >= 3 * P) begin
      bad++;
      $display("FAIL b2b_wait timeout got=%0d want<%0d", n, 3 * P);
    end
    nd1 = rnd_frame();
    nd2 = rnd_frame();
    frame_data = nd1;
    frame_valid = 1'b1;
    tick();
    frame_data = nd2;
    total++;
    if (frame_sync !== 1'b1 || frame_ready !== 1'b0 || got !== want) begin
      bad++;
      $display("FAIL b2b_accept got=%b want=%b", got, want);
    end
    for (int i = 1; i <= P; i++) begin
      tick();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL b2b i=%0d got=%b want=%b", i, got, want);
      end
    end
    total++;
    if (frame_sync !== 1'b1 || row_out !== nd1[R-1:0]) begin
      bad++;
      $display("FAIL b2b_show row=%b want=%b", row_out, nd1[R-1:0]);
    end
    tick();
    frame_valid = 1'b0;
    tick();
  endtask

  task automatic test_disable();
    int n;
    n = 0;
    while (!(m_run && ((m_p % P) / S) == 3 && (m_p % S) == 1) && n < 2 * P) begin
      tick();
      n++;
    end
    enable = 1'b0;
    tick();
    total++;
    if (n >= 2 * P || col_en !== 5'b11111 || row_out !== 7'b0 || got !== want) begin
      bad++;
      $display("FAIL disable got=%b want=%b", got, want);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL disable_idle got=%b want=%b", got, want);
      end
    end
    enable = 1'b1;
    tick();
    total++;
    if (col_en !== 5'b11110 || frame_sync !== 1'b1 || got !== want) begin
      bad++;
      $display("FAIL reenable got=%b want=%b", got, want);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    while (!(m_run && ((m_p % P) / S) == 4 && (m_p % S) == 0) && n < 2 * P) begin
      tick();
      n++;
    end
    frame_data = rnd_frame();
    frame_valid = 1'b1;
    tick();
    frame_valid = 1'b0;
    total++;
    if (n >= 2 * P || frame_ready !== 1'b0 || col_en !== 5'b01111) begin
      bad++;
      $display("FAIL rstmid_setup rdy=%b col=%b want 0/01111", frame_ready, col_en);
    end
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    total++;
    if (got !== 14'b11111_0000000_0_1) begin
      bad++;
      $display("FAIL rstmid_async got=%b want=%b", got, 14'b11111_0000000_0_1);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < P + 2; i++) begin
      tick();
      total++;
      if (got !== want || row_out !== 7'b0) begin
        bad++;
        $display("FAIL rstmid_after i=%0d got=%b want=%b", i, got, want);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      enable      = ($urandom_range(0, 24) != 0);
      frame_valid = ($urandom_range(0, 3) == 0);
      frame_data  = rnd_frame();
      tick();
      total++;
      if (got !== want) begin
        bad++;
        $display("FAIL random i=%0d got=%b want=%b", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_load();
    test_scan();
    test_midscan_load();
    test_back_to_back();
    test_disable();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
